// File: rtl/sprq_pkg.sv
// Shared types and default sizing for the sprite register commit queue.
package sprq_pkg;
  localparam int SPRQ_DEPTH  = 8;
  localparam int SPRQ_ADDR_W = 6;
  localparam int SPRQ_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SPRQ_ADDR_W-1:0] addr;
    logic [SPRQ_DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/sprq_fifo.sv
// Synchronous FIFO with head/tail visibility and an in-place tail overwrite port.
// The caller never pushes when full; pointers wrap naturally since DEPTH is a power of 2.
module sprq_fifo
  import sprq_pkg::*;
#(
  parameter int WIDTH = SPRQ_ADDR_W + SPRQ_DATA_W,
  parameter int DEPTH = SPRQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     ovw,
  input  logic [WIDTH-1:0]         ovw_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         tail_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    tail_ptr;

  assign tail_ptr  = wr_ptr - AW'(1);
  assign head_data = mem[rd_ptr];
  assign tail_data = mem[tail_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
    if (ovw)  mem[tail_ptr] <= ovw_data;
  end
endmodule

// File: rtl/sprite_reg_commit_queue.sv
// Holds CPU sprite register writes and replays them in order only while draining is allowed (vblank or flush).
// Define SPRQ_COALESCE_EN to merge a write into the tail entry when it targets the same address.
module sprite_reg_commit_queue
  import sprq_pkg::*;
#(
  parameter int DEPTH  = SPRQ_DEPTH,
  parameter int ADDR_W = SPRQ_ADDR_W,
  parameter int DATA_W = SPRQ_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   vblank_i,
  input  logic                   flush_req,
  input  logic                   ovf_clr,
  output logic                   reg_we,
  output logic [ADDR_W-1:0]      reg_addr,
  output logic [DATA_W-1:0]      reg_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   overflow,
  output logic                   commit_done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;

  state_t          state;
  logic            flush_pending;
  logic            drain_ok;
  logic            pop;
  logic            push;
  logic            ovw;
  logic            full;
  logic            empty;
  logic            last;
  logic            unused_tail;
  logic [EW-1:0]   head_data;
  logic [EW-1:0]   tail_data;

  assign drain_ok    = vblank_i || flush_pending;
  assign pop         = (state == ST_DRAIN) && drain_ok && !empty;
  assign unused_tail = ^tail_data;

`ifdef SPRQ_COALESCE_EN
  logic tail_hit;
  // A tail that is leaving this cycle cannot absorb the write.
  assign tail_hit = !empty && (tail_data[EW-1:DATA_W] == wr_addr) && !(pop && level == CW'(1));
  assign wr_ready = !full || tail_hit;
  assign ovw      = wr_valid && tail_hit;
  assign push     = wr_valid && wr_ready && !tail_hit;
`else
  assign wr_ready = !full;
  assign ovw      = 1'b0;
  assign push     = wr_valid && wr_ready;
`endif

  assign last = (level == CW'(1)) && !push;

  sprq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .ovw       (ovw),
    .ovw_data  ({wr_addr, wr_data}),
    .head_data (head_data),
    .tail_data (tail_data),
    .count     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      flush_pending <= 1'b0;
      busy          <= 1'b0;
      commit_done   <= 1'b0;
      overflow      <= 1'b0;
      reg_we        <= 1'b0;
      reg_addr      <= '0;
      reg_data      <= '0;
    end else begin
      commit_done <= 1'b0;
      reg_we      <= pop;
      if (pop) begin
        reg_addr <= head_data[EW-1:DATA_W];
        reg_data <= head_data[DATA_W-1:0];
      end

      if (wr_valid && !wr_ready) overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!empty && drain_ok) begin
            state <= ST_DRAIN;
            busy  <= 1'b1;
          end else if (empty && flush_pending) begin
            flush_pending <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!drain_ok) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (empty || last) begin
            state         <= ST_DONE;
            busy          <= 1'b0;
            commit_done   <= 1'b1;
            flush_pending <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A fresh flush request outranks any clear in the same cycle.
      if (flush_req) flush_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sprite_reg_commit_queue.sv
// Directed and randomized bench for sprite_reg_commit_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_sprite_reg_commit_queue;
  import sprq_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_DONE = 2;
`ifdef SPRQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          vblank_i = 1'b0;
  logic          flush_req = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, reg_we, busy, overflow, commit_done;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic [3:0]    level;

  always #5 clk = ~clk;

  sprite_reg_commit_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .vblank_i(vblank_i),
    .flush_req(flush_req), .ovf_clr(ovf_clr), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_data(reg_data), .level(level), .busy(busy),
    .overflow(overflow), .commit_done(commit_done)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents plus the drain phase and registered outputs.
  entry_t        mq[$];
  int            phase = P_IDLE;
  bit            m_fp, m_we, m_done, m_ovf;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  function automatic bit m_pop();
    return (phase == P_DRAIN) && (vblank_i || m_fp) && (mq.size() > 0);
  endfunction

  function automatic bit m_hit();
    if (!COAL || mq.size() == 0) return 1'b0;
    return (mq[mq.size()-1].addr == wr_addr) && !(m_pop() && mq.size() == 1);
  endfunction

  function automatic bit m_rdy();
    return (mq.size() < DEPTH) || m_hit();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      phase = P_IDLE; m_fp = 0; m_we = 0; m_done = 0; m_ovf = 0;
      m_addr = '0; m_data = '0;
    end else begin
      bit ok, pop, hit, rdy;
      int n0;
      entry_t t;
      n0 = mq.size();
      ok = vblank_i || m_fp;
      pop = m_pop(); hit = m_hit(); rdy = m_rdy();
      m_we = pop;
      m_done = 0;
      if (pop) begin m_addr = mq[0].addr; m_data = mq[0].data; end
      if (wr_valid && !rdy) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (wr_valid && rdy) begin
        if (hit) begin
          t = mq[mq.size()-1]; t.data = wr_data; mq[mq.size()-1] = t;
        end else begin
          t.addr = wr_addr; t.data = wr_data; mq.push_back(t);
        end
      end
      if (pop) void'(mq.pop_front());
      case (phase)
        P_IDLE: begin
          if (n0 > 0 && ok) phase = P_DRAIN;
          else if (n0 == 0 && m_fp) m_fp = 0;
        end
        P_DRAIN: begin
          if (!ok) phase = P_IDLE;
          else if (mq.size() == 0) begin phase = P_DONE; m_fp = 0; m_done = 1; end
        end
        default: phase = P_IDLE;
      endcase
      if (flush_req) m_fp = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("reg_we", reg_we, m_we);
      cmp("reg_addr", reg_addr, m_addr);
      cmp("reg_data", reg_data, m_data);
      cmp("level", level, mq.size());
      cmp("busy", busy, phase == P_DRAIN);
      cmp("overflow", overflow, m_ovf);
      cmp("commit_done", commit_done, m_done);
      cmp("wr_ready", wr_ready, m_rdy());
    end
  end

  // Log of register-file writes and commit pulses for directed checks.
  entry_t wlog[$];
  int     ndone = 0;
  always @(negedge clk) begin
    entry_t e;
    if (reg_we === 1'b1) begin e.addr = reg_addr; e.data = reg_data; wlog.push_back(e); end
    if (commit_done === 1'b1) ndone++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); @(negedge clk); #1; end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic clr_log();
    wlog.delete(); ndone = 0;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1; step(1); flush_req = 1'b0;
  endtask

  int vb_cnt = 0;

  initial begin
    step(2);
    chk_en = 1'b1;
    step(1);
    cmp("rst_level", level, 0);
    cmp("rst_reg_we", reg_we, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_overflow", overflow, 0);
    cmp("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    step(1);

    // Deferred commit
    push(6'h04, 16'h1020);
    push(6'h06, 16'hAAAA);
    step(3);
    cmp("defer_level", level, 2);
    cmp("defer_no_write", wlog.size(), 0);
    vblank_i = 1'b1;
    step(6);
    cmp("defer_nwrites", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      cmp("defer_w0_addr", wlog[0].addr, 6'h04);
      cmp("defer_w0_data", wlog[0].data, 16'h1020);
      cmp("defer_w1_addr", wlog[1].addr, 6'h06);
      cmp("defer_w1_data", wlog[1].data, 16'hAAAA);
    end
    cmp("defer_done", ndone, 1);
    cmp("defer_level0", level, 0);
    vblank_i = 1'b0;
    step(2);

    // Split window
    for (int i = 0; i < 5; i++) push(AW'(6'h10 + i), DW'(16'h5000 + i));
    clr_log();
    vblank_i = 1'b1;
    step(3);
    vblank_i = 1'b0;
    step(4);
    cmp("split_first_nwrites", wlog.size(), 2);
    cmp("split_level", level, 3);
    cmp("split_busy", busy, 0);
    cmp("split_no_done", ndone, 0);
    vblank_i = 1'b1;
    step(8);
    vblank_i = 1'b0;
    cmp("split_total", wlog.size(), 5);
    for (int i = 0; i < wlog.size(); i++) cmp("split_order", wlog[i].addr, 6'h10 + i);
    cmp("split_done", ndone, 1);
    step(2);

    // Full / overflow
    for (int i = 0; i < 8; i++) push(AW'(6'h20 + i), DW'(16'h7700 + i));
    wr_addr = 6'h3F;
    step(1);
    cmp("full_ready", wr_ready, 0);
    cmp("full_level", level, 8);
    push(6'h3F, 16'hDEAD);
    cmp("ovf_set", overflow, 1);
    cmp("ovf_level", level, 8);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    cmp("ovf_clr", overflow, 0);
    wr_valid = 1'b1; ovf_clr = 1'b1; wr_addr = 6'h3F;
    step(1);
    wr_valid = 1'b0; ovf_clr = 1'b0;
    cmp("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    clr_log();
    pulse_flush();
    step(12);
    cmp("full_flush_level", level, 0);
    cmp("full_flush_writes", wlog.size(), 8);

    // Flush
    for (int i = 1; i <= 3; i++) push(AW'(i), DW'(16'h0100 * i));
    clr_log();
    pulse_flush();
    step(8);
    cmp("flush_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) cmp("flush_last_addr", wlog[2].addr, 6'h03);
    cmp("flush_done", ndone, 1);
    clr_log();
    pulse_flush();
    step(5);
    cmp("flush_empty_writes", wlog.size(), 0);
    cmp("flush_empty_done", ndone, 0);

    // Reset mid-drain
    for (int i = 0; i < 4; i++) push(AW'(6'h30 + i), DW'(16'h3000 + i));
    clr_log();
    vblank_i = 1'b1;
    for (int i = 0; i < 10 && wlog.size() == 0; i++) step(1);
    cmp("rmd_first_write", wlog.size(), 1);
    rst_n = 1'b0;
    step(1);
    cmp("rmd_reg_we", reg_we, 0);
    cmp("rmd_level", level, 0);
    cmp("rmd_busy", busy, 0);
    rst_n = 1'b1;
    step(6);
    cmp("rmd_no_more", wlog.size(), 1);
    vblank_i = 1'b0;
    step(1);

    // Same-address pair: merged with coalescing, two entries without
    push(6'h0E, 16'h1111);
    push(6'h0E, 16'h2222);
    cmp("coal_level", level, COAL ? 1 : 2);
    clr_log();
    vblank_i = 1'b1;
    step(8);
    vblank_i = 1'b0;
    cmp("coal_nwrites", wlog.size(), COAL ? 1 : 2);
    if (wlog.size() > 0) cmp("coal_last_data", wlog[wlog.size()-1].data, 16'h2222);
    step(2);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (vb_cnt == 0) begin
        vblank_i = ~vblank_i;
        vb_cnt = vblank_i ? $urandom_range(1, 12) : $urandom_range(3, 30);
      end
      vb_cnt--;
      wr_valid  = ($urandom_range(0, 99) < 45);
      wr_addr   = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wr_data   = DW'($urandom);
      flush_req = ($urandom_range(0, 59) == 0);
      ovf_clr   = ($urandom_range(0, 24) == 0);
      rst_n     = ($urandom_range(0, 799) != 0);
      step(1);
    end
    wr_valid = 1'b0; flush_req = 1'b0; ovf_clr = 1'b0; rst_n = 1'b1; vblank_i = 1'b1;
    step(20);
    cmp("final_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
